systolic_seq_ctrl: RTL and testbench

- Sequencer for the 4-PE systolic array. Accepts one byte stream from the host and routes it, in order, to per-PE weight loads, per-PE bias loads and the data stream.
- Generates skewed per-PE accumulate enables and waits for the pipeline to flush.
- Drains the four accumulators through the array's drain mux onto a valid/ready result port.

---
 rtl/systolic_seq_ctrl_if.sv | 19 +
 rtl/systolic_seq_ctrl.sv | 118 +++++++++++
 tb/tb_systolic_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_if.sv
// Host-side stream handshake for the systolic sequencer: byte input stream
// and drained-accumulator result stream.
interface systolic_seq_ctrl_if #(
   parameter int DW = 8,
   parameter int AW = 16
) ();
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_idx;

   modport master (output in_data, in_valid, out_ready,
                   input  in_ready, out_data, out_valid, out_idx);
   modport slave  (input  in_data, in_valid, out_ready,
                   output in_ready, out_data, out_valid, out_idx);
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 4-PE systolic array: routes one host byte stream into weight,
// bias and data loads, skews accumulate enables, flushes, then drains results.
module systolic_seq_ctrl #(
   parameter int NUM_PE    = 4,
   parameter int DW        = 8,
   parameter int AW        = 16,
   parameter int CNT_W     = 8,
   parameter int FLUSH_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cfg_load_wb,
   input  logic [CNT_W-1:0]  cfg_num_samples,
   output logic              busy,
   output logic              done,
   systolic_seq_ctrl_if.slave hs,
   output logic [DW-1:0]     arr_data_in,
   output logic [DW-1:0]     arr_weight_in,
   output logic [DW-1:0]     arr_bias_in,
   output logic [NUM_PE-1:0] arr_pe_weight_en,
   output logic [NUM_PE-1:0] arr_pe_bias_en,
   output logic [NUM_PE-1:0] arr_pe_acc_en,
   output logic [1:0]        arr_drain_sel,
   input  logic [AW-1:0]     arr_final_acc_out
);
   localparam int               FL_W    = $clog2(FLUSH_LAT + 1);
   localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLUSH_LAT - 1);
   localparam logic [FL_W-1:0]  FL_ONE  = FL_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [1:0]       IDX_LAST = 2'(NUM_PE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_LOAD_B, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
   } state_t;

   state_t             r_state, w_nxt;
   logic [CNT_W-1:0]   r_num, r_cnt;
   logic [1:0]         r_idx;
   logic [FL_W-1:0]    r_fcnt;
   logic [NUM_PE-1:1]  r_vld_pipe;

   logic               w_acc, w_out_hs, w_idx_last, w_stream_acc, w_idx_adv;
   logic [CNT_W-1:0]   w_num_m1;
   logic [NUM_PE-1:0]  w_onehot;

   assign w_acc        = hs.in_valid & hs.in_ready;
   assign w_out_hs     = hs.out_valid & hs.out_ready;
   assign w_idx_last   = (r_idx == IDX_LAST);
   assign w_num_m1     = r_num - CNT_ONE;
   assign w_stream_acc = (r_state == S_STREAM) & w_acc;
   assign w_idx_adv    = (w_acc & (r_state != S_STREAM)) | w_out_hs;
   assign w_onehot     = NUM_PE'(1) << r_idx;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:
            if (start)
               w_nxt = cfg_load_wb ? S_LOAD_W
                     : ((cfg_num_samples == '0) ? S_DRAIN : S_STREAM);
         S_LOAD_W: if (w_acc && w_idx_last) w_nxt = S_LOAD_B;
         S_LOAD_B: if (w_acc && w_idx_last) w_nxt = (r_num == '0) ? S_DRAIN : S_STREAM;
         S_STREAM: if (w_acc && (r_cnt == w_num_m1)) w_nxt = S_FLUSH;
         S_FLUSH:  if (r_fcnt == FL_LAST) w_nxt = S_DRAIN;
         S_DRAIN:  if (w_out_hs && w_idx_last) w_nxt = S_DONE;
         S_DONE:   w_nxt = S_IDLE;
         default:  w_nxt = S_IDLE;
      endcase
   end

   // Everything below is a pure function of state, so an async reset drops
   // every enable in the same instant the state register clears.
   assign busy             = (r_state != S_IDLE);
   assign done             = (r_state == S_DONE);
   assign hs.in_ready      = (r_state == S_LOAD_W) | (r_state == S_LOAD_B) | (r_state == S_STREAM);
   assign arr_weight_in    = (r_state == S_LOAD_W) ? hs.in_data : '0;
   assign arr_bias_in      = (r_state == S_LOAD_B) ? hs.in_data : '0;
   assign arr_pe_weight_en = ((r_state == S_LOAD_W) && w_acc) ? w_onehot : '0;
   assign arr_pe_bias_en   = ((r_state == S_LOAD_B) && w_acc) ? w_onehot : '0;
   assign arr_data_in      = w_stream_acc ? hs.in_data : '0;
   assign arr_pe_acc_en    = ((r_state == S_STREAM) || (r_state == S_FLUSH))
                             ? {r_vld_pipe, w_stream_acc} : '0;
   assign hs.out_valid     = (r_state == S_DRAIN);
   assign hs.out_idx       = hs.out_valid ? r_idx : '0;
   assign arr_drain_sel    = hs.out_valid ? r_idx : '0;
   assign hs.out_data      = hs.out_valid ? arr_final_acc_out : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_num      <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_fcnt     <= '0;
         r_vld_pipe <= '0;
      end else begin
         r_state <= w_nxt;
         if ((r_state == S_IDLE) && start)
            r_num <= cfg_num_samples;

         if (w_nxt != r_state)  r_idx <= '0;
         else if (w_idx_adv)    r_idx <= r_idx + 2'd1;

         if (r_state != S_STREAM) r_cnt <= '0;
         else if (w_acc)          r_cnt <= r_cnt + CNT_ONE;

         if (r_state != S_FLUSH) r_fcnt <= '0;
         else                    r_fcnt <= r_fcnt + FL_ONE;

         // Shifts every STREAM/FLUSH cycle so input bubbles travel down the chain.
         if ((r_state == S_STREAM) || (r_state == S_FLUSH))
            r_vld_pipe <= {r_vld_pipe[NUM_PE-2:1], w_stream_acc};
         else
            r_vld_pipe <= '0;
      end
   end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: behavioural 4-PE array model plus a drain
// scoreboard filled from the intended weights, biases and samples.
module tb_systolic_seq_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_load_wb = 1'b0;
   logic [7:0]  cfg_num_samples = 8'd0;
   logic        busy, done;
   logic [7:0]  arr_data_in, arr_weight_in, arr_bias_in;
   logic [3:0]  arr_pe_weight_en, arr_pe_bias_en, arr_pe_acc_en;
   logic [1:0]  arr_drain_sel;
   logic [15:0] arr_final_acc_out;
   logic [15:0] fa_xor = 16'd0;

   int n_cmp = 0, n_err = 0, done_cnt = 0;
   bit wb_seen = 0, rdy_seen = 0;
   logic [17:0] sb_q[$];
   logic [3:0]  en_q[$];
   logic [7:0]  ew[4], eb[4];

   systolic_seq_ctrl_if #(.DW(8), .AW(16)) hs ();

   systolic_seq_ctrl #(.NUM_PE(4), .DW(8), .AW(16), .CNT_W(8), .FLUSH_LAT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_load_wb(cfg_load_wb),
      .cfg_num_samples(cfg_num_samples), .busy(busy), .done(done), .hs(hs),
      .arr_data_in(arr_data_in), .arr_weight_in(arr_weight_in), .arr_bias_in(arr_bias_in),
      .arr_pe_weight_en(arr_pe_weight_en), .arr_pe_bias_en(arr_pe_bias_en),
      .arr_pe_acc_en(arr_pe_acc_en), .arr_drain_sel(arr_drain_sel),
      .arr_final_acc_out(arr_final_acc_out)
   );

   initial forever #5 clk = ~clk;

   // Array model: PE i sees the data stream delayed i cycles.
   logic [7:0]  m_w[4], m_b[4], m_x[4];
   logic [15:0] m_acc[4];
   assign arr_final_acc_out = m_acc[arr_drain_sel] ^ fa_xor;

   always @(posedge clk) begin
      logic [7:0] xi;
      m_x[1] <= arr_data_in; m_x[2] <= m_x[1]; m_x[3] <= m_x[2];
      for (int i = 0; i < 4; i++) begin
         xi = (i == 0) ? arr_data_in : m_x[i];
         if (arr_pe_weight_en[i]) m_w[i] <= arr_weight_in;
         if (arr_pe_bias_en[i]) begin
            m_b[i] <= arr_bias_in; m_acc[i] <= {8'd0, arr_bias_in};
         end else if (start && !busy) m_acc[i] <= {8'd0, m_b[i]};
         else if (arr_pe_acc_en[i]) m_acc[i] <= m_acc[i] + {8'd0, m_w[i]} * {8'd0, xi};
      end
   end

   // Drain scoreboard and sticky event flags.
   always @(negedge clk) if (rst_n) begin
      logic [17:0] e;
      if (arr_pe_weight_en != 0 || arr_pe_bias_en != 0) wb_seen = 1;
      if (hs.in_ready) rdy_seen = 1;
      if (done) done_cnt++;
      if (hs.out_valid && hs.out_ready) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++; $display("FAIL drain_extra: got idx %0d data %0d, want no output", hs.out_idx, hs.out_data);
         end else begin
            e = sb_q.pop_front();
            if ({hs.out_idx, hs.out_data} !== e) begin
               n_err++;
               $display("FAIL drain: got idx %0d data %0d, want idx %0d data %0d", hs.out_idx, hs.out_data, e[17:16], e[15:0]);
            end
         end
      end
   end

   task automatic step(); @(posedge clk); #1; endtask

   task automatic push_exp(input logic [15:0] sum);
      for (int i = 0; i < 4; i++)
         sb_q.push_back({2'(i), {8'd0, eb[i]} + {8'd0, ew[i]} * sum});
   endtask

   task automatic begin_job(input bit lw, input logic [7:0] n);
      step(); start = 1; cfg_load_wb = lw; cfg_num_samples = n;
      step(); start = 0;
   endtask

   task automatic run_to_done(output bit ok);
      ok = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) begin ok = 1; break; end
         step();
      end
      if (ok) step();
   endtask

   task automatic test_reset();
      hs.in_valid = 1; hs.in_data = 8'hAA; hs.out_ready = 1;
      #12;
      n_cmp++; if ({busy, done, hs.in_ready, hs.out_valid} !== 4'b0) begin
         n_err++; $display("FAIL reset_ctl: got %b want 0000", {busy, done, hs.in_ready, hs.out_valid}); end
      n_cmp++; if ({arr_pe_weight_en, arr_pe_bias_en, arr_pe_acc_en} !== 12'b0) begin
         n_err++; $display("FAIL reset_en: got %h want 000", {arr_pe_weight_en, arr_pe_bias_en, arr_pe_acc_en}); end
      n_cmp++; if ({arr_data_in, arr_weight_in, arr_bias_in, arr_drain_sel, hs.out_idx, hs.out_data} !== 44'b0) begin
         n_err++; $display("FAIL reset_data: got %h want 0", {arr_data_in, arr_weight_in, arr_bias_in, arr_drain_sel, hs.out_idx, hs.out_data}); end
      hs.in_valid = 0;
      step(); rst_n = 1; step();
   endtask

   task automatic test_full_job();
      logic [7:0] bytes [11];
      logic [3:0] oh, e;
      bit ok;
      int d0;
      bytes = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10, 8'd20, 8'd30};
      ew = '{8'd1, 8'd2, 8'd3, 8'd4}; eb = '{8'd5, 8'd6, 8'd7, 8'd8};
      push_exp(16'd60);
      en_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      d0 = done_cnt;
      begin_job(1, 8'd3);
      for (int c = 0; c < 15; c++) begin
         hs.in_valid = (c < 11); hs.in_data = (c < 11) ? bytes[c] : 8'd0;
         #1;
         n_cmp++;
         if (c < 8) begin
            oh = 4'b0001 << (c % 4);
            if (c < 4 && {arr_pe_weight_en, arr_weight_in} !== {oh, bytes[c]}) begin
               n_err++; $display("FAIL full_w%0d: got %b/%0d want %b/%0d", c, arr_pe_weight_en, arr_weight_in, oh, bytes[c]); end
            if (c >= 4 && {arr_pe_bias_en, arr_bias_in} !== {oh, bytes[c]}) begin
               n_err++; $display("FAIL full_b%0d: got %b/%0d want %b/%0d", c, arr_pe_bias_en, arr_bias_in, oh, bytes[c]); end
         end else begin
            e = en_q.pop_front();
            if (arr_pe_acc_en !== e) begin
               n_err++; $display("FAIL full_acc_en c%0d: got %b want %b", c, arr_pe_acc_en, e); end
         end
         step();
      end
      n_cmp++; if ({hs.out_valid, hs.out_idx} !== 3'b100) begin
         n_err++; $display("FAIL full_drain_start: got valid %b idx %0d want 1/0", hs.out_valid, hs.out_idx); end
      run_to_done(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL full_timeout: got no done want done"); end
      n_cmp++; if (done_cnt !== d0 + 1 || busy !== 1'b0) begin
         n_err++; $display("FAIL full_done: got %0d pulses busy %b want 1 pulse busy 0", done_cnt - d0, busy); end
      n_cmp++; if (sb_q.size() != 0) begin
         n_err++; $display("FAIL full_sb_left: got %0d pending want 0", sb_q.size()); end
   endtask

   task automatic test_bubble();
      logic [3:0] e;
      bit ok;
      push_exp(16'd16);
      en_q = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0000};
      begin_job(0, 8'd2);
      for (int c = 0; c < 7; c++) begin
         hs.in_valid = (c == 0 || c == 2); hs.in_data = (c == 0) ? 8'd7 : 8'd9;
         #1;
         e = en_q.pop_front();
         n_cmp++; if (arr_pe_acc_en !== e) begin
            n_err++; $display("FAIL bubble_acc_en c%0d: got %b want %b", c, arr_pe_acc_en, e); end
         if (c == 3) begin
            n_cmp++; if (hs.in_ready !== 1'b0) begin
               n_err++; $display("FAIL bubble_ready: got %b want 0", hs.in_ready); end
         end
         step();
      end
      hs.in_valid = 0;
      run_to_done(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bubble_timeout: got no done want done"); end
   endtask

   task automatic test_backpressure();
      logic [15:0] e1;
      bit ok;
      e1 = {8'd0, eb[1]} + {8'd0, ew[1]} * 16'd3;
      push_exp(16'd3);
      hs.out_ready = 0;
      begin_job(0, 8'd1);
      hs.in_valid = 1; hs.in_data = 8'd3; step(); hs.in_valid = 0;
      for (int c = 0; c < 20; c++) begin
         if (hs.out_valid) break;
         step();
      end
      n_cmp++; if ({hs.out_valid, hs.out_idx} !== 3'b100) begin
         n_err++; $display("FAIL bp_first: got valid %b idx %0d want 1/0", hs.out_valid, hs.out_idx); end
      hs.out_ready = 1; step();
      for (int j = 0; j < 3; j++) begin
         hs.out_ready = 0; fa_xor = 16'h0100 << j;
         #1;
         n_cmp++; if ({hs.out_valid, hs.out_idx, arr_drain_sel, hs.out_data} !== {1'b1, 2'd1, 2'd1, e1 ^ fa_xor}) begin
            n_err++; $display("FAIL bp_hold%0d: got v%b i%0d s%0d d%h want v1 i1 s1 d%h", j, hs.out_valid, hs.out_idx, arr_drain_sel, hs.out_data, e1 ^ fa_xor); end
         step();
      end
      fa_xor = 0; hs.out_ready = 1;
      step();
      n_cmp++; if ({hs.out_idx, arr_drain_sel} !== 4'b1010) begin
         n_err++; $display("FAIL bp_advance: got idx %0d sel %0d want 2/2", hs.out_idx, arr_drain_sel); end
      run_to_done(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: got no done want done"); end
   endtask

   task automatic test_reuse();
      bit ok;
      push_exp(16'd24);
      wb_seen = 0;
      begin_job(0, 8'd2);
      hs.in_valid = 1; hs.in_data = 8'd11; #1;
      n_cmp++; if (arr_data_in !== 8'd11) begin
         n_err++; $display("FAIL reuse_data: got %0d want 11", arr_data_in); end
      step(); hs.in_data = 8'd13; step(); hs.in_valid = 0;
      run_to_done(ok);
      n_cmp++; if (!ok || wb_seen) begin
         n_err++; $display("FAIL reuse_wb: got done %b wb_seen %b want 1/0", ok, wb_seen); end
   endtask

   task automatic test_zero();
      bit ok;
      push_exp(16'd0);
      hs.in_valid = 1; hs.in_data = 8'h55;
      rdy_seen = 0;
      begin_job(0, 8'd0);
      n_cmp++; if (hs.out_valid !== 1'b1) begin
         n_err++; $display("FAIL zero_drain: got out_valid %b want 1", hs.out_valid); end
      run_to_done(ok);
      hs.in_valid = 0;
      n_cmp++; if (!ok || rdy_seen) begin
         n_err++; $display("FAIL zero_ready: got done %b rdy_seen %b want 1/0", ok, rdy_seen); end
   endtask

   task automatic test_start_ignored();
      bit ok;
      push_exp(16'd10);
      begin_job(0, 8'd4);
      for (int k = 0; k < 4; k++) begin
         hs.in_valid = 1; hs.in_data = 8'(k + 1);
         start = (k == 1); if (k == 1) begin cfg_load_wb = 1; cfg_num_samples = 8'd1; end
         #1;
         n_cmp++; if (hs.in_ready !== 1'b1) begin
            n_err++; $display("FAIL ign_ready%0d: got %b want 1", k, hs.in_ready); end
         step();
      end
      start = 0; hs.in_valid = 0; #1;
      n_cmp++; if (hs.in_ready !== 1'b0) begin
         n_err++; $display("FAIL ign_flush: got in_ready %b want 0", hs.in_ready); end
      run_to_done(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL ign_timeout: got no done want done"); end
   endtask

   task automatic test_abort();
      int d0;
      d0 = done_cnt;
      begin_job(0, 8'd3);
      hs.in_valid = 1; hs.in_data = 8'd9; #1;
      n_cmp++; if (arr_pe_acc_en !== 4'b0001) begin
         n_err++; $display("FAIL abort_pre: got %b want 0001", arr_pe_acc_en); end
      #1; rst_n = 0; #1;
      n_cmp++; if ({arr_pe_weight_en, arr_pe_bias_en, arr_pe_acc_en, busy, hs.in_ready, hs.out_valid} !== 15'b0) begin
         n_err++; $display("FAIL abort_drop: got %b want 0", {arr_pe_weight_en, arr_pe_bias_en, arr_pe_acc_en, busy, hs.in_ready, hs.out_valid}); end
      hs.in_valid = 0;
      step(); step(); rst_n = 1; step();
      n_cmp++; if (done_cnt !== d0 || busy !== 1'b0) begin
         n_err++; $display("FAIL abort_done: got %0d pulses busy %b want 0/0", done_cnt - d0, busy); end
   endtask

   task automatic test_after_abort();
      logic [7:0] bytes [9];
      bit ok;
      bytes = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd10};
      ew = '{8'd2, 8'd3, 8'd4, 8'd5}; eb = '{8'd1, 8'd1, 8'd1, 8'd1};
      push_exp(16'd10);
      begin_job(1, 8'd1);
      for (int c = 0; c < 9; c++) begin
         hs.in_valid = 1; hs.in_data = bytes[c]; #1;
         n_cmp++; if (hs.in_ready !== 1'b1) begin
            n_err++; $display("FAIL fresh_ready%0d: got %b want 1", c, hs.in_ready); end
         step();
      end
      hs.in_valid = 0;
      run_to_done(ok);
      n_cmp++; if (!ok || sb_q.size() != 0) begin
         n_err++; $display("FAIL fresh_end: got done %b pending %0d want 1/0", ok, sb_q.size()); end
   endtask

   initial begin
      hs.in_valid = 0; hs.in_data = 0; hs.out_ready = 1;
      test_reset();
      test_full_job();
      test_bubble();
      test_backpressure();
      test_reuse();
      test_zero();
      test_start_ignored();
      test_abort();
      test_after_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
